// File: rtl/exception_ctrl_if.sv
// Exception-report bundle between the MEM stage, WB-stage CP0 writes and the
// exception controller. The master side is the pipeline; the slave side is
// the controller itself.
interface exception_ctrl_if;
  // MEM-stage instruction state
  logic        mem_valid_i;
  logic [7:0]  excflags_i;
  logic [31:0] inst_addr_i;
  logic        in_delayslot_i;
  logic [31:0] mem_addr_i;

  // CP0 registers as currently registered
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;

  // WB-stage CP0 write port, forwarded into the decision
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_data_i;

  // Registered exception report
  logic [31:0] excepttype_o;
  logic [31:0] inst_addr_o;
  logic        in_delayslot_o;
  logic [31:0] badvaddr_o;
  logic        flush_o;
  logic [31:0] new_pc_o;

  modport master (
    output mem_valid_i, excflags_i, inst_addr_i, in_delayslot_i, mem_addr_i,
    output cp0_status_i, cp0_cause_i, cp0_epc_i,
    output wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
    input  excepttype_o, inst_addr_o, in_delayslot_o, badvaddr_o, flush_o, new_pc_o
  );

  modport slave (
    input  mem_valid_i, excflags_i, inst_addr_i, in_delayslot_i, mem_addr_i,
    input  cp0_status_i, cp0_cause_i, cp0_epc_i,
    input  wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
    output excepttype_o, inst_addr_o, in_delayslot_o, badvaddr_o, flush_o, new_pc_o
  );
endinterface

// File: rtl/exception_ctrl.sv
// MEM-stage exception controller. Resolves exception priority with CP0 values
// forwarded from WB, then emits a one-cycle registered report (code, PC,
// delay-slot flag, BadVAddr) together with flush and the redirect PC. A
// single drain cycle follows each report while the flushed bubble passes.
module exception_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic [31:0] ADEL_CODE  = 32'h0000_0004,
  parameter logic [31:0] ADES_CODE  = 32'h0000_0005
) (
  input  logic             clk,
  input  logic             rst,
  exception_ctrl_if.slave  bus
);

  localparam logic [31:0] CodeInt  = 32'h0000_0001;
  localparam logic [31:0] CodeSys  = 32'h0000_0008;
  localparam logic [31:0] CodeBrk  = 32'h0000_0009;
  localparam logic [31:0] CodeInv  = 32'h0000_000a;
  localparam logic [31:0] CodeOvf  = 32'h0000_000c;
  localparam logic [31:0] CodeTrap = 32'h0000_000d;
  localparam logic [31:0] CodeEret = 32'h0000_000e;

  localparam logic [4:0] RegStatus = 5'd12;
  localparam logic [4:0] RegCause  = 5'd13;
  localparam logic [4:0] RegEpc    = 5'd14;

  typedef enum logic [1:0] {
    StIdle,
    StReport,
    StDrain
  } state_e;

  state_e state_q, state_d;

  logic [31:0] code_q, code_d;
  logic [31:0] pc_q, pc_d;
  logic        ds_q, ds_d;
  logic [31:0] bad_q, bad_d;
  logic [31:0] new_pc_q, new_pc_d;

  // Only the Status/Cause fields that feed the interrupt decision are kept.
  logic [7:0]  status_im;
  logic        status_ie;
  logic        status_exl;
  logic [7:0]  cause_ip;
  logic [31:0] eff_epc;
  logic        int_pend;

  logic        sel_valid;
  logic        sel_eret;
  logic [31:0] sel_code;
  logic [31:0] sel_bad;

  // Forward a same-cycle WB write to Status/Cause/EPC into the decision.
  // A Cause write only replaces bits 23, 22 and 9:8; of those only the
  // software interrupt bits 9:8 matter to the pending-interrupt test.
  always_comb begin
    status_im  = bus.cp0_status_i[15:8];
    status_ie  = bus.cp0_status_i[0];
    status_exl = bus.cp0_status_i[1];
    cause_ip   = bus.cp0_cause_i[15:8];
    eff_epc    = bus.cp0_epc_i;
    if (bus.wb_cp0_we_i) begin
      if (bus.wb_cp0_waddr_i == RegStatus) begin
        status_im  = bus.wb_cp0_data_i[15:8];
        status_ie  = bus.wb_cp0_data_i[0];
        status_exl = bus.wb_cp0_data_i[1];
      end
      if (bus.wb_cp0_waddr_i == RegCause) begin
        cause_ip[1:0] = bus.wb_cp0_data_i[9:8];
      end
      if (bus.wb_cp0_waddr_i == RegEpc) begin
        eff_epc = bus.wb_cp0_data_i;
      end
    end
  end

  // Interrupt is pending when an unmasked line is raised, IE set and EXL clear.
  always_comb begin
    int_pend = (|(cause_ip & status_im)) & status_ie & ~status_exl;
  end

  // Fixed-priority selection; bubbles never raise anything.
  always_comb begin
    sel_valid = 1'b0;
    sel_eret  = 1'b0;
    sel_code  = 32'h0;
    sel_bad   = 32'h0;
    if (bus.mem_valid_i) begin
      sel_valid = 1'b1;
      if (int_pend) begin
        sel_code = CodeInt;
      end else if (bus.excflags_i[3]) begin
        sel_code = CodeInv;
      end else if (bus.excflags_i[5]) begin
        sel_code = CodeOvf;
      end else if (bus.excflags_i[4]) begin
        sel_code = CodeTrap;
      end else if (bus.excflags_i[0]) begin
        sel_code = CodeSys;
      end else if (bus.excflags_i[1]) begin
        sel_code = CodeBrk;
      end else if (bus.excflags_i[6]) begin
        sel_code = ADEL_CODE;
        sel_bad  = bus.mem_addr_i;
      end else if (bus.excflags_i[7]) begin
        sel_code = ADES_CODE;
        sel_bad  = bus.mem_addr_i;
      end else if (bus.excflags_i[2]) begin
        sel_code = CodeEret;
        sel_eret = 1'b1;
      end else begin
        sel_valid = 1'b0;
      end
    end
  end

  // Next state and report capture; capture happens only on the IDLE->REPORT edge.
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    pc_d     = pc_q;
    ds_d     = ds_q;
    bad_d    = bad_q;
    new_pc_d = new_pc_q;
    case (state_q)
      StIdle: begin
        if (sel_valid) begin
          state_d  = StReport;
          code_d   = sel_code;
          pc_d     = bus.inst_addr_i;
          ds_d     = bus.in_delayslot_i;
          bad_d    = sel_bad;
          new_pc_d = sel_eret ? eff_epc : EXC_VECTOR;
        end
      end
      StReport: state_d = StDrain;
      StDrain:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State and report registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      code_q   <= 32'h0;
      pc_q     <= 32'h0;
      ds_q     <= 1'b0;
      bad_q    <= 32'h0;
      new_pc_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      pc_q     <= pc_d;
      ds_q     <= ds_d;
      bad_q    <= bad_d;
      new_pc_q <= new_pc_d;
    end
  end

  // The report is visible only during the single REPORT cycle.
  always_comb begin
    bus.excepttype_o   = 32'h0;
    bus.inst_addr_o    = 32'h0;
    bus.in_delayslot_o = 1'b0;
    bus.badvaddr_o     = 32'h0;
    bus.flush_o        = 1'b0;
    bus.new_pc_o       = 32'h0;
    if (state_q == StReport) begin
      bus.excepttype_o   = code_q;
      bus.inst_addr_o    = pc_q;
      bus.in_delayslot_o = ds_q;
      bus.badvaddr_o     = bad_q;
      bus.flush_o        = 1'b1;
      bus.new_pc_o       = new_pc_q;
    end
  end

endmodule

// File: tb/tb_exception_ctrl.sv
// Scoreboard bench for exception_ctrl: each driven cycle pushes the expected
// post-edge outputs from a small reference model; they are popped and
// compared one cycle later against what the DUT shows.
module tb_exception_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;

  exception_ctrl_if bus ();

  exception_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        valid;
    logic [7:0]  flags;
    logic [31:0] pc;
    logic        ds;
    logic [31:0] maddr;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } stim_t;

  typedef struct {
    logic [31:0] code;
    logic [31:0] pc;
    logic        ds;
    logic [31:0] bad;
    logic        flush;
    logic [31:0] new_pc;
  } exp_t;

  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_err = 0;
  int    m_st = 0;  // model state: 0 idle, 1 report, 2 drain
  string cur_test = "reset";

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s.%s: got %h expected %h", cur_test, tag, got, exp);
    end
  endtask

  function automatic exp_t zero_exp();
    exp_t e;
    e.code = 32'h0; e.pc = 32'h0; e.ds = 1'b0;
    e.bad = 32'h0; e.flush = 1'b0; e.new_pc = 32'h0;
    return e;
  endfunction

  function automatic stim_t nop();
    stim_t s;
    s.rst = 1'b0; s.valid = 1'b0; s.flags = 8'h0; s.pc = 32'h0; s.ds = 1'b0;
    s.maddr = 32'h0; s.status = 32'h0; s.cause = 32'h0; s.epc = 32'h0;
    s.we = 1'b0; s.waddr = 5'd0; s.wdata = 32'h0;
    return s;
  endfunction

  // Report that an IDLE controller would register for this stimulus.
  function automatic exp_t predict(input stim_t s);
    exp_t        e;
    logic [31:0] st;
    logic [31:0] ca;
    logic [31:0] ep;
    logic        ip;
    e  = zero_exp();
    st = (s.we && s.waddr == 5'd12) ? s.wdata : s.status;
    ep = (s.we && s.waddr == 5'd14) ? s.wdata : s.epc;
    ca = s.cause;
    if (s.we && s.waddr == 5'd13) begin
      ca[23]  = s.wdata[23];
      ca[22]  = s.wdata[22];
      ca[9:8] = s.wdata[9:8];
    end
    ip = (|(ca[15:8] & st[15:8])) && st[0] && !st[1];
    if (!s.valid) return e;
    e.flush  = 1'b1;
    e.pc     = s.pc;
    e.ds     = s.ds;
    e.new_pc = 32'hBFC0_0380;
    if (ip)               e.code = 32'h1;
    else if (s.flags[3])  e.code = 32'ha;
    else if (s.flags[5])  e.code = 32'hc;
    else if (s.flags[4])  e.code = 32'hd;
    else if (s.flags[0])  e.code = 32'h8;
    else if (s.flags[1])  e.code = 32'h9;
    else if (s.flags[6])  begin e.code = 32'h4; e.bad = s.maddr; end
    else if (s.flags[7])  begin e.code = 32'h5; e.bad = s.maddr; end
    else if (s.flags[2])  begin e.code = 32'he; e.new_pc = ep; end
    else                  e = zero_exp();
    return e;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    @(negedge clk);
    rst                = s.rst;
    bus.mem_valid_i    = s.valid;
    bus.excflags_i     = s.flags;
    bus.inst_addr_i    = s.pc;
    bus.in_delayslot_i = s.ds;
    bus.mem_addr_i     = s.maddr;
    bus.cp0_status_i   = s.status;
    bus.cp0_cause_i    = s.cause;
    bus.cp0_epc_i      = s.epc;
    bus.wb_cp0_we_i    = s.we;
    bus.wb_cp0_waddr_i = s.waddr;
    bus.wb_cp0_data_i  = s.wdata;
    e = zero_exp();
    if (s.rst) begin
      m_st = 0;
    end else if (m_st == 0) begin
      e    = predict(s);
      m_st = e.flush ? 1 : 0;
    end else if (m_st == 1) begin
      m_st = 2;
    end else begin
      m_st = 0;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("excepttype", bus.excepttype_o, e.code);
    check("inst_addr", bus.inst_addr_o, e.pc);
    check("in_delayslot", {31'd0, bus.in_delayslot_o}, {31'd0, e.ds});
    check("badvaddr", bus.badvaddr_o, e.bad);
    check("flush", {31'd0, bus.flush_o}, {31'd0, e.flush});
    check("new_pc", bus.new_pc_o, e.new_pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    bus.mem_valid_i = 1'b0; bus.excflags_i = 8'h0; bus.inst_addr_i = 32'h0;
    bus.in_delayslot_i = 1'b0; bus.mem_addr_i = 32'h0; bus.cp0_status_i = 32'h0;
    bus.cp0_cause_i = 32'h0; bus.cp0_epc_i = 32'h0; bus.wb_cp0_we_i = 1'b0;
    bus.wb_cp0_waddr_i = 5'd0; bus.wb_cp0_data_i = 32'h0;

    // Reset holds everything at zero even with an exception presented
    s = nop(); s.rst = 1'b1; s.valid = 1'b1; s.flags = 8'h01;
    step(s); step(s);
    s = nop(); step(s);

    // T1: syscall
    cur_test = "t1";
    s = nop(); s.valid = 1'b1; s.flags = 8'h01; s.pc = 32'h8000_1000;
    step(s);
    check("lit_code", bus.excepttype_o, 32'h8);
    check("lit_new_pc", bus.new_pc_o, 32'hBFC0_0380);
    s = nop(); step(s); step(s);

    // T2: enabled interrupt, then same with EXL set
    cur_test = "t2";
    s = nop(); s.valid = 1'b1; s.status = 32'h0000_0401; s.cause = 32'h0000_0400;
    s.pc = 32'h8000_0040;
    step(s);
    check("lit_code", bus.excepttype_o, 32'h1);
    s = nop(); step(s); step(s);
    s = nop(); s.valid = 1'b1; s.status = 32'h0000_0403; s.cause = 32'h0000_0400;
    step(s);
    check("lit_exl_flush", {31'd0, bus.flush_o}, 32'h0);

    // T3: WB clearing Status in the same cycle suppresses the interrupt
    cur_test = "t3";
    s = nop(); s.valid = 1'b1; s.status = 32'h0000_0401; s.cause = 32'h0000_0400;
    s.we = 1'b1; s.waddr = 5'd12; s.wdata = 32'h0;
    step(s);
    s = nop(); step(s);

    // Cause forwarding: only bits 9:8 of a Cause write reach the interrupt test
    cur_test = "cause_fwd";
    s = nop(); s.valid = 1'b1; s.status = 32'h0000_0101;
    s.we = 1'b1; s.waddr = 5'd13; s.wdata = 32'h0000_0100;
    step(s);
    s = nop(); step(s); step(s);
    s = nop(); s.valid = 1'b1; s.status = 32'h0000_0401;
    s.we = 1'b1; s.waddr = 5'd13; s.wdata = 32'h0000_0400;
    step(s);
    s = nop(); step(s);

    // T4: eret redirects to the forwarded EPC
    cur_test = "t4";
    s = nop(); s.valid = 1'b1; s.flags = 8'h04; s.epc = 32'h8000_0000;
    s.we = 1'b1; s.waddr = 5'd14; s.wdata = 32'h8000_2000; s.pc = 32'h8000_0300;
    step(s);
    check("lit_code", bus.excepttype_o, 32'he);
    check("lit_new_pc", bus.new_pc_o, 32'h8000_2000);
    s = nop(); step(s); step(s);

    // T5: overflow beats store misalign; then load misalign alone
    cur_test = "t5";
    s = nop(); s.valid = 1'b1; s.flags = 8'hA0; s.ds = 1'b1; s.maddr = 32'h8000_0103;
    s.pc = 32'h8000_0500;
    step(s);
    check("lit_code", bus.excepttype_o, 32'hc);
    check("lit_bad", bus.badvaddr_o, 32'h0);
    s = nop(); step(s); step(s);
    s = nop(); s.valid = 1'b1; s.flags = 8'h40; s.maddr = 32'h8000_0103;
    step(s);
    check("lit_bad_adel", bus.badvaddr_o, 32'h8000_0103);
    s = nop(); step(s); step(s);

    // Bubbles never report
    cur_test = "bubble";
    s = nop(); s.flags = 8'hFF; s.status = 32'h0000_ff01; s.cause = 32'h0000_ff00;
    step(s);

    // T6: syscall held through REPORT and DRAIN is ignored; then reset in REPORT
    cur_test = "t6";
    s = nop(); s.valid = 1'b1; s.flags = 8'h01; s.pc = 32'h8000_0600;
    step(s); step(s); step(s);
    s = nop(); step(s);
    s = nop(); s.valid = 1'b1; s.flags = 8'h01; s.pc = 32'h8000_0700;
    step(s);
    s = nop(); s.rst = 1'b1; s.valid = 1'b1; s.flags = 8'h01;
    step(s);
    s = nop(); s.valid = 1'b1; s.flags = 8'h02; s.pc = 32'h8000_0800;
    step(s);
    check("lit_brk_after_rst", bus.excepttype_o, 32'h9);
    s = nop(); step(s); step(s);

    // Random mix against the model
    cur_test = "rand";
    for (int i = 0; i < 400; i++) begin
      s = nop();
      s.rst    = ($urandom_range(0, 59) == 0);
      s.valid  = ($urandom_range(0, 3) != 0);
      s.flags  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h0;
      s.pc     = $urandom;
      s.ds     = 1'($urandom);
      s.maddr  = $urandom;
      s.status = {16'h0, 8'($urandom), 6'h0, 2'($urandom)};
      s.cause  = ($urandom_range(0, 3) == 0) ? {8'h0, 8'($urandom), 8'($urandom), 8'h0} : 32'h0;
      s.epc    = $urandom;
      s.we     = 1'($urandom);
      case ($urandom_range(0, 3))
        0: s.waddr = 5'd12;
        1: s.waddr = 5'd13;
        2: s.waddr = 5'd14;
        default: s.waddr = 5'd9;
      endcase
      s.wdata  = $urandom;
      step(s);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
